// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse master sequencer.
// Holds the FSM state encoding, PS/2 command/response bytes and receiver error codes.
package mouse_pkg;

   localparam int CNT_W    = 27;
   localparam int SYNC_BIT = 3;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_STREAM = 8'hF4;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] RSP_DEV_ID = 8'h00;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_PARITY = 2'b01,
      ERR_STOP   = 2'b10
   } rx_err_e;

   typedef enum logic [3:0] {
      ST_INIT_WAIT,
      ST_SEND_FF,
      ST_WAIT_SENT_FF,
      ST_WAIT_FA1,
      ST_WAIT_AA,
      ST_WAIT_ID,
      ST_SEND_F4,
      ST_WAIT_SENT_F4,
      ST_WAIT_FA2,
      ST_STREAM_B0,
      ST_STREAM_B1,
      ST_STREAM_B2,
      ST_INTERRUPT
   } state_e;

   // States in which the shared wait counter runs toward a terminal count.
   function automatic logic is_timed(input state_e st);
      return st inside {ST_INIT_WAIT, ST_WAIT_SENT_FF, ST_WAIT_FA1, ST_WAIT_AA,
                        ST_WAIT_ID, ST_WAIT_SENT_F4, ST_WAIT_FA2,
                        ST_STREAM_B1, ST_STREAM_B2};
   endfunction

   function automatic logic rx_match(input logic [7:0] rx,
                                     input logic [1:0] err,
                                     input logic [7:0] expected);
      return (err == ERR_NONE) && (rx == expected);
   endfunction

endpackage

// File: rtl/mouse_wait_counter.sv
// Cycle counter with clear, enable and terminal-count compare against a runtime limit.
// A zero limit never reaches terminal count, which is how timeouts get disabled.
module mouse_wait_counter #(
   parameter int W = 27
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en && (limit != '0) && (cnt_q == limit - W'(1));

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: reset/enable handshake with the device, then 3-byte stream packet capture.
//
// state           | meaning
// ST_INIT_WAIT    | power-up settle delay before talking to the mouse
// ST_SEND_FF      | request transmit of reset command FF
// ST_WAIT_SENT_FF | wait for transmitter to report FF delivered
// ST_WAIT_FA1     | expect ACK FA for the reset command
// ST_WAIT_AA      | expect self-test pass AA
// ST_WAIT_ID      | expect device id 00
// ST_SEND_F4      | request transmit of enable-streaming command F4
// ST_WAIT_SENT_F4 | wait for transmitter to report F4 delivered
// ST_WAIT_FA2     | expect ACK FA for F4
// ST_STREAM_B0    | hunt for packet byte 0 (bit3 set), no timeout
// ST_STREAM_B1    | expect packet byte 1 within the byte gap
// ST_STREAM_B2    | expect packet byte 2 within the byte gap
// ST_INTERRUPT    | new packet on MOUSE_*, one-cycle interrupt
module mouse_master_sm
   import mouse_pkg::*;
#(
   parameter int unsigned INIT_DELAY = 5_000_000,
   parameter int unsigned TIMEOUT    = 50_000_000,
   parameter int unsigned BYTE_GAP   = 100_000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic       CONFIGURED
);

   localparam logic [CNT_W-1:0] INIT_LIM    = CNT_W'(INIT_DELAY);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(BYTE_GAP);

   state_e     state_q, state_d;
   logic [7:0] status_sh_q, status_sh_d;
   logic [7:0] dx_sh_q, dx_sh_d;
   logic [7:0] mouse_status_q, mouse_status_d;
   logic [7:0] mouse_dx_q, mouse_dx_d;
   logic [7:0] mouse_dy_q, mouse_dy_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_limit;
   logic             rx_ok;

   assign rx_ok = (BYTE_ERROR_CODE == ERR_NONE);

   always_comb begin
      cnt_limit = TIMEOUT_LIM;
      if (state_q == ST_INIT_WAIT) begin
         cnt_limit = INIT_LIM;
      end else if (state_q inside {ST_STREAM_B1, ST_STREAM_B2}) begin
         cnt_limit = GAP_LIM;
      end
   end

   // Every state change restarts the count, so one counter serves all waits.
   assign cnt_en  = is_timed(state_q);
   assign cnt_clr = (state_d != state_q);

   mouse_wait_counter #(
      .W (CNT_W)
   ) u_wait_counter (
      .clk_sys (CLK),
      .rst_b   (RESET),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .limit   (cnt_limit),
      .tc      (cnt_tc)
   );

   always_comb begin
      state_d        = state_q;
      status_sh_d    = status_sh_q;
      dx_sh_d        = dx_sh_q;
      mouse_status_d = mouse_status_q;
      mouse_dx_d     = mouse_dx_q;
      mouse_dy_d     = mouse_dy_q;
      case (state_q)
         ST_INIT_WAIT: begin
            if (cnt_tc) state_d = ST_SEND_FF;
         end
         ST_SEND_FF: state_d = ST_WAIT_SENT_FF;
         ST_WAIT_SENT_FF: begin
            if (BYTE_SENT)   state_d = ST_WAIT_FA1;
            else if (cnt_tc) state_d = ST_INIT_WAIT;
         end
         // A byte arriving on the timeout cycle takes priority over the timeout.
         ST_WAIT_FA1: begin
            if (BYTE_READY)
               state_d = rx_match(BYTE_READ, BYTE_ERROR_CODE, RSP_ACK) ? ST_WAIT_AA : ST_INIT_WAIT;
            else if (cnt_tc)
               state_d = ST_INIT_WAIT;
         end
         ST_WAIT_AA: begin
            if (BYTE_READY)
               state_d = rx_match(BYTE_READ, BYTE_ERROR_CODE, RSP_BAT_OK) ? ST_WAIT_ID : ST_INIT_WAIT;
            else if (cnt_tc)
               state_d = ST_INIT_WAIT;
         end
         ST_WAIT_ID: begin
            if (BYTE_READY)
               state_d = rx_match(BYTE_READ, BYTE_ERROR_CODE, RSP_DEV_ID) ? ST_SEND_F4 : ST_INIT_WAIT;
            else if (cnt_tc)
               state_d = ST_INIT_WAIT;
         end
         ST_SEND_F4: state_d = ST_WAIT_SENT_F4;
         ST_WAIT_SENT_F4: begin
            if (BYTE_SENT)   state_d = ST_WAIT_FA2;
            else if (cnt_tc) state_d = ST_INIT_WAIT;
         end
         ST_WAIT_FA2: begin
            if (BYTE_READY)
               state_d = rx_match(BYTE_READ, BYTE_ERROR_CODE, RSP_ACK) ? ST_STREAM_B0 : ST_INIT_WAIT;
            else if (cnt_tc)
               state_d = ST_INIT_WAIT;
         end
         ST_STREAM_B0: begin
            if (BYTE_READY && rx_ok && BYTE_READ[SYNC_BIT]) begin
               status_sh_d = BYTE_READ;
               state_d     = ST_STREAM_B1;
            end
         end
         ST_STREAM_B1: begin
            if (BYTE_READY) begin
               if (rx_ok) begin
                  dx_sh_d = BYTE_READ;
                  state_d = ST_STREAM_B2;
               end else begin
                  state_d = ST_STREAM_B0;
               end
            end else if (cnt_tc) begin
               state_d = ST_STREAM_B0;
            end
         end
         // Published registers load on the way into ST_INTERRUPT so data and pulse coincide.
         ST_STREAM_B2: begin
            if (BYTE_READY) begin
               if (rx_ok) begin
                  mouse_status_d = status_sh_q;
                  mouse_dx_d     = dx_sh_q;
                  mouse_dy_d     = BYTE_READ;
                  state_d        = ST_INTERRUPT;
               end else begin
                  state_d = ST_STREAM_B0;
               end
            end else if (cnt_tc) begin
               state_d = ST_STREAM_B0;
            end
         end
         ST_INTERRUPT: state_d = ST_STREAM_B0;
         default:      state_d = ST_INIT_WAIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q        <= ST_INIT_WAIT;
         status_sh_q    <= '0;
         dx_sh_q        <= '0;
         mouse_status_q <= '0;
         mouse_dx_q     <= '0;
         mouse_dy_q     <= '0;
      end else begin
         state_q        <= state_d;
         status_sh_q    <= status_sh_d;
         dx_sh_q        <= dx_sh_d;
         mouse_status_q <= mouse_status_d;
         mouse_dx_q     <= mouse_dx_d;
         mouse_dy_q     <= mouse_dy_d;
      end
   end

   always_comb begin
      BYTE_TO_SEND = 8'h00;
      case (state_q)
         ST_SEND_FF, ST_WAIT_SENT_FF: BYTE_TO_SEND = CMD_RESET;
         ST_SEND_F4, ST_WAIT_SENT_F4: BYTE_TO_SEND = CMD_STREAM;
         default:                     BYTE_TO_SEND = 8'h00;
      endcase
   end

   assign SEND_BYTE      = (state_q == ST_SEND_FF) || (state_q == ST_SEND_F4);
   assign READ_ENABLE    = state_q inside {ST_WAIT_FA1, ST_WAIT_AA, ST_WAIT_ID, ST_WAIT_FA2,
                                           ST_STREAM_B0, ST_STREAM_B1, ST_STREAM_B2};
   assign CONFIGURED     = state_q inside {ST_STREAM_B0, ST_STREAM_B1, ST_STREAM_B2, ST_INTERRUPT};
   assign SEND_INTERRUPT = (state_q == ST_INTERRUPT);
   assign MOUSE_STATUS   = mouse_status_q;
   assign MOUSE_DX       = mouse_dx_q;
   assign MOUSE_DY       = mouse_dy_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: handshake, packets, resync, byte-gap, restart and reset cases.
module tb_mouse_master_sm;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic       CONFIGURED;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   mouse_master_sm #(
      .INIT_DELAY (10),
      .TIMEOUT    (200),
      .BYTE_GAP   (50)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .SEND_BYTE       (SEND_BYTE),
      .BYTE_TO_SEND    (BYTE_TO_SEND),
      .BYTE_SENT       (BYTE_SENT),
      .READ_ENABLE     (READ_ENABLE),
      .BYTE_READ       (BYTE_READ),
      .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
      .BYTE_READY      (BYTE_READY),
      .MOUSE_STATUS    (MOUSE_STATUS),
      .MOUSE_DX        (MOUSE_DX),
      .MOUSE_DY        (MOUSE_DY),
      .SEND_INTERRUPT  (SEND_INTERRUPT),
      .CONFIGURED      (CONFIGURED)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // All tasks start and end on a falling edge; inputs set here are sampled at the next rise.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   task automatic pulse_sent();
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
   endtask

   task automatic pulse_ready(input logic [7:0] b, input logic [1:0] err);
      BYTE_READY      = 1'b1;
      BYTE_READ       = b;
      BYTE_ERROR_CODE = err;
      @(negedge CLK);
      BYTE_READY      = 1'b0;
      BYTE_ERROR_CODE = 2'b00;
   endtask

   task automatic wait_send(input int max, output int n);
      n = -1;
      for (int i = 0; i <= max; i++) begin
         if (SEND_BYTE === 1'b1) begin
            n = i;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic chk_packet(input string tag, input logic [7:0] st, input logic [7:0] dx,
                             input logic [7:0] dy);
      chk(tag, {8'h00, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {8'h00, st, dx, dy});
   endtask

   initial begin
      int n;
      RESET           = 1'b0;
      BYTE_SENT       = 1'b0;
      BYTE_READ       = 8'h00;
      BYTE_ERROR_CODE = 2'b00;
      BYTE_READY      = 1'b0;
      step(3);

      chk("rst_flags", {28'h0, SEND_BYTE, READ_ENABLE, CONFIGURED, SEND_INTERRUPT}, 32'h0);
      chk("rst_tx_byte", {24'h0, BYTE_TO_SEND}, 32'h0);
      chk_packet("rst_mouse", 8'h00, 8'h00, 8'h00);

      // Happy-path handshake.
      RESET = 1'b1;
      wait_send(40, n);
      chk("init_delay_ff", n, 10);
      chk("ff_byte", {24'h0, BYTE_TO_SEND}, 32'hFF);
      chk("ff_read_en", {31'h0, READ_ENABLE}, 32'h0);
      step(1);
      chk("ff_one_cycle", {31'h0, SEND_BYTE}, 32'h0);
      chk("ff_held", {24'h0, BYTE_TO_SEND}, 32'hFF);
      pulse_sent();
      chk("fa1_read_en", {31'h0, READ_ENABLE}, 32'h1);
      pulse_ready(8'hFA, 2'b00);
      pulse_ready(8'hAA, 2'b00);
      pulse_ready(8'h00, 2'b00);
      wait_send(5, n);
      chk("f4_sent_now", n, 0);
      chk("f4_byte", {24'h0, BYTE_TO_SEND}, 32'hF4);
      step(1);
      pulse_sent();
      chk("fa2_not_cfg", {31'h0, CONFIGURED}, 32'h0);
      pulse_ready(8'hFA, 2'b00);
      chk("configured", {30'h0, CONFIGURED, READ_ENABLE}, 32'h3);

      // First packet.
      pulse_ready(8'h08, 2'b00);
      pulse_ready(8'h05, 2'b00);
      chk("pkt1_no_irq_early", {31'h0, SEND_INTERRUPT}, 32'h0);
      pulse_ready(8'hFB, 2'b00);
      chk("pkt1_irq", {31'h0, SEND_INTERRUPT}, 32'h1);
      chk_packet("pkt1_data", 8'h08, 8'h05, 8'hFB);
      step(1);
      chk("pkt1_irq_one_cycle", {31'h0, SEND_INTERRUPT}, 32'h0);
      chk_packet("pkt1_hold", 8'h08, 8'h05, 8'hFB);

      // Resync in B0 and parity error in B1.
      pulse_ready(8'h00, 2'b00);
      pulse_ready(8'h09, 2'b00);
      pulse_ready(8'h33, 2'b01);
      pulse_ready(8'h44, 2'b00);
      chk("resync_no_irq", {31'h0, SEND_INTERRUPT}, 32'h0);
      chk_packet("resync_hold", 8'h08, 8'h05, 8'hFB);
      pulse_ready(8'h28, 2'b00);
      pulse_ready(8'h7F, 2'b00);
      pulse_ready(8'h80, 2'b00);
      chk("pkt2_irq", {31'h0, SEND_INTERRUPT}, 32'h1);
      chk_packet("pkt2_data", 8'h28, 8'h7F, 8'h80);
      step(1);

      // Byte landing on the byte-gap terminal cycle is accepted.
      pulse_ready(8'h18, 2'b00);
      step(49);
      pulse_ready(8'h11, 2'b00);
      pulse_ready(8'h22, 2'b00);
      chk("gap_edge_irq", {31'h0, SEND_INTERRUPT}, 32'h1);
      chk_packet("gap_edge_data", 8'h18, 8'h11, 8'h22);
      step(1);

      // Byte-gap expiry drops the partial packet.
      pulse_ready(8'h08, 2'b00);
      step(50);
      pulse_ready(8'h01, 2'b00);
      pulse_ready(8'h02, 2'b00);
      chk("gap_expire_no_irq", {31'h0, SEND_INTERRUPT}, 32'h0);
      chk_packet("gap_expire_hold", 8'h18, 8'h11, 8'h22);
      chk("gap_expire_cfg", {31'h0, CONFIGURED}, 32'h1);

      // Reset in the middle of a packet.
      pulse_ready(8'h08, 2'b00);
      RESET = 1'b0;
      step(1);
      chk("midrst_flags", {28'h0, SEND_BYTE, READ_ENABLE, CONFIGURED, SEND_INTERRUPT}, 32'h0);
      chk_packet("midrst_mouse", 8'h00, 8'h00, 8'h00);
      RESET = 1'b1;
      wait_send(40, n);
      chk("midrst_ff", n, 10);

      // Wrong self-test response restarts the sequence.
      step(1);
      pulse_sent();
      pulse_ready(8'hFA, 2'b00);
      pulse_ready(8'hFE, 2'b00);
      chk("bad_aa_state", {30'h0, READ_ENABLE, CONFIGURED}, 32'h0);
      wait_send(40, n);
      chk("bad_aa_ff_again", n, 10);
      chk("bad_aa_ff_byte", {24'h0, BYTE_TO_SEND}, 32'hFF);

      // No BYTE_SENT: 200-cycle timeout, then 10-cycle init delay.
      step(1);
      wait_send(400, n);
      chk("timeout_ff_again", n, 210);
      chk("timeout_ff_byte", {24'h0, BYTE_TO_SEND}, 32'hFF);
      chk("timeout_not_cfg", {31'h0, CONFIGURED}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
